// File: rtl/risc5_arith_pkg.sv
// Shared float field constants, cycle-count defaults and an operand unpack helper
// for the RISC5 multi-cycle arithmetic unit.
package risc5_arith_pkg;

    localparam int         EXP_BIAS    = 127;
    localparam logic [7:0] EXP_INF     = 8'hFF;
    localparam int         MANT_W      = 23;

    localparam int         DIV_CYC_DEF = 33;
    localparam int         FAD_CYC_DEF = 2;
    localparam int         FDV_CYC_DEF = 25;

    typedef struct packed {
        logic              sgn;
        logic [7:0]        exp;
        logic [MANT_W:0]   mant;
    } fp_unp_t;

    // Exponent 0 is an exact zero: no hidden bit, fraction ignored.
    function automatic fp_unp_t fp_unpack(input logic [31:0] f);
        fp_unp_t u;
        u.sgn  = f[31];
        u.exp  = f[30:23];
        u.mant = (f[30:23] == 8'd0) ? '0 : {1'b1, f[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round (nearest, ties away from zero) and pack a single-precision result.
// Input value is mant / 2^30 * 2^(exp - bias); mant may carry into bit 31 or lead lower.
module fp_round_pack
    import risc5_arith_pkg::*;
(
    input  logic              sgn,
    input  logic signed [9:0] exp,
    input  logic [31:0]       mant,
    output logic [31:0]       res
);

    localparam logic signed [9:0] EXP_MAX = {2'b00, EXP_INF};

    logic [4:0]        lead;
    logic [24:0]       norm;
    logic [24:0]       rnd;
    logic signed [9:0] exp_r;

    always_comb begin
        lead = '0;
        for (int i = 0; i < 32; i++) begin
            if (mant[i]) lead = 5'(i);
        end
        // Leading one to bit 24; bit 0 is the guard bit.
        norm  = 25'((mant << (5'd31 - lead)) >> 7);
        rnd   = {1'b0, norm[24:1]} + {24'd0, norm[0]};
        exp_r = exp + 10'(lead) - 10'sd30 + 10'(rnd[24]);

        if (!rnd[24] && !rnd[23])
            res = '0;
        else if (exp_r >= EXP_MAX)
            res = {sgn, EXP_INF, 23'd0};
        else if (exp_r <= 10'sd0)
            res = '0;
        else
            res = {sgn, exp_r[7:0], rnd[22:0]};
    end

endmodule

// File: rtl/risc5_muldiv_fp_unit.sv
// RISC5 multi-cycle arithmetic: floored integer divide, FP add/FLT/FLOOR and FP divide,
// each an independent engine that stalls the pipeline while it runs.
module risc5_muldiv_fp_unit
    import risc5_arith_pkg::*;
#(
    parameter int DIV_CYC = DIV_CYC_DEF,
    parameter int FAD_CYC = FAD_CYC_DEF,
    parameter int FDV_CYC = FDV_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        div_run,
    input  logic        div_sgn,
    input  logic        fad_run,
    input  logic        fad_u,
    input  logic        fad_v,
    input  logic        fdv_run,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        div_stall,
    output logic        fad_stall,
    output logic        fdv_stall,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic [31:0] fsum,
    output logic [31:0] fquot
);

    localparam int DIV_CW = $clog2(DIV_CYC + 1);
    localparam int FAD_CW = $clog2(FAD_CYC + 1);
    localparam int FDV_CW = $clog2(FDV_CYC + 1);

    // ---------------- integer divide ----------------
    logic [DIV_CW-1:0] div_cnt_reg;
    logic [31:0]       div_r_reg, div_q_reg, quot_reg, rem_reg;
    logic              div_neg, div_ge, div_rnz;
    logic [31:0]       div_absx, div_r_next, div_q_next, div_quot_fin, div_rem_fin;
    logic [32:0]       div_sh, div_diff;

    assign div_stall = div_run & (div_cnt_reg != DIV_CW'(DIV_CYC));

    always_comb begin
        div_neg    = div_sgn & x[31];
        div_absx   = div_neg ? -x : x;
        div_sh     = {div_r_reg, div_q_reg[31]};
        div_diff   = div_sh - {1'b0, y};
        div_ge     = (div_sh >= {1'b0, y});
        div_r_next = div_ge ? 32'(div_diff) : 32'(div_sh);
        div_q_next = {div_q_reg[30:0], div_ge};
        div_rnz    = |div_r_next;
        // Negative signed dividend: turn truncated result into floor with 0 <= rem < y.
        if (y == '0) begin
            div_quot_fin = '1;
            div_rem_fin  = x;
        end else if (div_neg) begin
            div_quot_fin = -div_q_next - {31'd0, div_rnz};
            div_rem_fin  = div_rnz ? (y - div_r_next) : '0;
        end else begin
            div_quot_fin = div_q_next;
            div_rem_fin  = div_r_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            div_r_reg   <= '0;
            div_q_reg   <= '0;
            quot_reg    <= '0;
            rem_reg     <= '0;
        end else if (en) begin
            if (!div_run) begin
                div_cnt_reg <= '0;
            end else if (div_stall) begin
                div_cnt_reg <= div_cnt_reg + DIV_CW'(1);
                if (div_cnt_reg == '0) begin
                    div_r_reg <= '0;
                    div_q_reg <= div_absx;
                end else begin
                    div_r_reg <= div_r_next;
                    div_q_reg <= div_q_next;
                    if (div_cnt_reg == DIV_CW'(DIV_CYC - 1)) begin
                        quot_reg <= div_quot_fin;
                        rem_reg  <= div_rem_fin;
                    end
                end
            end
        end
    end

    // ---------------- FP add / FLT / FLOOR ----------------
    logic [FAD_CW-1:0] fad_cnt_reg;
    logic              fad_sgn_reg;
    logic signed [9:0] fad_exp_reg;
    logic [31:0]       fad_mant_reg, fsum_reg, fad_rp_res;
    fp_unp_t           fx, fy, fa, fb;
    logic              fad_swap, st1_sgn, flr_fnz;
    logic [7:0]        fad_d;
    logic [31:0]       fad_ma, fad_mbf, fad_mb, fad_sum, flt_mag, st1_mant;
    logic signed [9:0] st1_exp, flr_e;
    logic [4:0]        flr_sh;
    logic [31:0]       flr_m, flr_ip, flr_res;

    assign fad_stall = fad_run & (fad_cnt_reg != FAD_CW'(FAD_CYC));

    always_comb begin
        fx       = fp_unpack(x);
        fy       = fp_unpack(y);
        fad_swap = (y[30:0] > x[30:0]);
        fa       = fad_swap ? fy : fx;
        fb       = fad_swap ? fx : fy;
        fad_d    = fa.exp - fb.exp;
        fad_ma   = {1'b0, fa.mant, 7'd0};
        fad_mbf  = {1'b0, fb.mant, 7'd0};
        // Bits shifted out of the smaller operand collapse into a sticky LSB.
        if (fad_d >= 8'd31)
            fad_mb = {31'd0, |fad_mbf};
        else
            fad_mb = (fad_mbf >> fad_d) | {31'd0, |(fad_mbf & ((32'd1 << fad_d) - 32'd1))};
        fad_sum  = (fa.sgn == fb.sgn) ? (fad_ma + fad_mb) : (fad_ma - fad_mb);
        flt_mag  = x[31] ? -x : x;

        if (fad_u) begin
            st1_sgn  = x[31];
            st1_exp  = 10'(EXP_BIAS + 30);
            st1_mant = flt_mag;
        end else begin
            st1_sgn  = fa.sgn;
            st1_exp  = {2'b00, fa.exp};
            st1_mant = fad_sum;
        end

        flr_e   = 10'(fx.exp) - 10'(EXP_BIAS);
        flr_sh  = flr_e[4:0];
        flr_m   = {8'd0, fx.mant};
        flr_fnz = 1'b0;
        if (flr_sh >= 5'd23) begin
            flr_ip = flr_m << (flr_sh - 5'd23);
        end else begin
            flr_ip  = flr_m >> (5'd23 - flr_sh);
            flr_fnz = |(flr_m & ((32'd1 << (5'd23 - flr_sh)) - 32'd1));
        end
        if (fx.exp == '0)
            flr_res = '0;
        else if (flr_e < 10'sd0)
            flr_res = fx.sgn ? '1 : '0;
        else if (flr_e >= 10'sd31)
            flr_res = fx.sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            flr_res = fx.sgn ? -(flr_ip + {31'd0, flr_fnz}) : flr_ip;
    end

    fp_round_pack u_rp_fad (
        .sgn  (fad_sgn_reg),
        .exp  (fad_exp_reg),
        .mant (fad_mant_reg),
        .res  (fad_rp_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fad_cnt_reg  <= '0;
            fad_sgn_reg  <= 1'b0;
            fad_exp_reg  <= '0;
            fad_mant_reg <= '0;
            fsum_reg     <= '0;
        end else if (en) begin
            if (!fad_run) begin
                fad_cnt_reg <= '0;
            end else if (fad_stall) begin
                fad_cnt_reg <= fad_cnt_reg + FAD_CW'(1);
                if (fad_cnt_reg == '0) begin
                    fad_sgn_reg  <= st1_sgn;
                    fad_exp_reg  <= st1_exp;
                    fad_mant_reg <= st1_mant;
                end
                if (fad_cnt_reg == FAD_CW'(FAD_CYC - 1))
                    fsum_reg <= (fad_v & ~fad_u) ? flr_res : fad_rp_res;
            end
        end
    end

    // ---------------- FP divide ----------------
    logic [FDV_CW-1:0] fdv_cnt_reg;
    logic [24:0]       fdv_r_reg, fdv_r_cur, fdv_r_sub, fdv_r_next, fdv_q_next;
    logic [23:0]       fdv_q_reg, fdv_q_cur;
    logic [31:0]       fquot_reg, fdv_rp_res, fdv_res;
    logic              fdv_lt, fdv_ge;
    logic signed [9:0] fdv_exp;

    assign fdv_stall = fdv_run & (fdv_cnt_reg != FDV_CW'(FDV_CYC));

    always_comb begin
        // Pre-scale the dividend so the quotient always lands in [1,2) and keeps a guard bit.
        fdv_lt     = (fx.mant < fy.mant);
        fdv_exp    = 10'(fx.exp) - 10'(fy.exp) + 10'(EXP_BIAS) - 10'(fdv_lt);
        if (fdv_cnt_reg == '0) begin
            fdv_r_cur = fdv_lt ? {fx.mant, 1'b0} : {1'b0, fx.mant};
            fdv_q_cur = '0;
        end else begin
            fdv_r_cur = fdv_r_reg;
            fdv_q_cur = fdv_q_reg;
        end
        fdv_ge     = (fdv_r_cur >= {1'b0, fy.mant});
        fdv_r_sub  = fdv_ge ? (fdv_r_cur - {1'b0, fy.mant}) : fdv_r_cur;
        fdv_r_next = 25'(fdv_r_sub << 1);
        fdv_q_next = {fdv_q_cur, fdv_ge};
        if (fx.exp == '0)
            fdv_res = '0;
        else if (fy.exp == '0)
            fdv_res = {fx.sgn ^ fy.sgn, EXP_INF, 23'd0};
        else
            fdv_res = fdv_rp_res;
    end

    fp_round_pack u_rp_fdv (
        .sgn  (fx.sgn ^ fy.sgn),
        .exp  (fdv_exp),
        .mant ({1'b0, fdv_q_next, 6'd0}),
        .res  (fdv_rp_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fdv_cnt_reg <= '0;
            fdv_r_reg   <= '0;
            fdv_q_reg   <= '0;
            fquot_reg   <= '0;
        end else if (en) begin
            if (!fdv_run) begin
                fdv_cnt_reg <= '0;
            end else if (fdv_stall) begin
                fdv_cnt_reg <= fdv_cnt_reg + FDV_CW'(1);
                fdv_r_reg   <= fdv_r_next;
                fdv_q_reg   <= fdv_q_next[23:0];
                if (fdv_cnt_reg == FDV_CW'(FDV_CYC - 1))
                    fquot_reg <= fdv_res;
            end
        end
    end

    assign quot  = quot_reg;
    assign rem   = rem_reg;
    assign fsum  = fsum_reg;
    assign fquot = fquot_reg;

endmodule

// File: tb/tb_risc5_muldiv_fp_unit.sv
// Directed self-checking bench for risc5_muldiv_fp_unit: hand-computed vectors per engine
// plus clock-enable, abort and reset behaviour.
module tb_risc5_muldiv_fp_unit;

    logic        clk, rst, en;
    logic        div_run, div_sgn, fad_run, fad_u, fad_v, fdv_run;
    logic [31:0] x, y;
    logic        div_stall, fad_stall, fdv_stall;
    logic [31:0] quot, rem, fsum, fquot;

    int compared   = 0;
    int mismatched = 0;
    int n;

    risc5_muldiv_fp_unit dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_run   (div_run),
        .div_sgn   (div_sgn),
        .fad_run   (fad_run),
        .fad_u     (fad_u),
        .fad_v     (fad_v),
        .fdv_run   (fdv_run),
        .x         (x),
        .y         (y),
        .div_stall (div_stall),
        .fad_stall (fad_stall),
        .fdv_stall (fdv_stall),
        .quot      (quot),
        .rem       (rem),
        .fsum      (fsum),
        .fquot     (fquot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-12s observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic cur_stall(input int eng);
        case (eng)
            0:       return div_stall;
            1:       return fad_stall;
            default: return fdv_stall;
        endcase
    endfunction

    // Starts one engine and counts stall-high cycles until the result is valid.
    task automatic run_op(input int eng, input logic [31:0] ax, input logic [31:0] ay,
                          input logic f1, input logic f2, output int ncyc);
        x = ax;
        y = ay;
        case (eng)
            0:       begin div_sgn = f1; div_run = 1'b1; end
            1:       begin fad_u = f1; fad_v = f2; fad_run = 1'b1; end
            default: fdv_run = 1'b1;
        endcase
        ncyc = 0;
        #1;
        while (cur_stall(eng) && ncyc < 100) begin
            ncyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drop();
        div_run = 1'b0;
        fad_run = 1'b0;
        fdv_run = 1'b0;
        fad_u   = 1'b0;
        fad_v   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        div_run = 1'b0; div_sgn = 1'b0; fad_run = 1'b0; fad_u = 1'b0; fad_v = 1'b0; fdv_run = 1'b0;
        x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quot", quot, 32'h0);
        check("rst_rem", rem, 32'h0);
        check("rst_fsum", fsum, 32'h0);
        check("rst_fquot", fquot, 32'h0);
        check("rst_stalls", {29'd0, div_stall, fad_stall, fdv_stall}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Integer divide
        run_op(0, 32'd7, 32'd2, 1'b1, 1'b0, n);
        check("div_cyc", 32'(n), 32'd33);
        check("div_7_2_q", quot, 32'd3);
        check("div_7_2_r", rem, 32'd1);
        @(posedge clk);
        #1;
        check("div_hold_q", quot, 32'd3);
        drop();
        run_op(0, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, n);
        check("sdiv_neg_q", quot, 32'hFFFF_FFFC);
        check("sdiv_neg_r", rem, 32'd1);
        drop();
        run_op(0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, n);
        check("udiv_q", quot, 32'h7FFF_FFFC);
        check("udiv_r", rem, 32'd1);
        drop();
        run_op(0, 32'hFFFF_FFF8, 32'd2, 1'b1, 1'b0, n);
        check("sdiv_exact_q", quot, 32'hFFFF_FFFC);
        check("sdiv_exact_r", rem, 32'd0);
        drop();
        run_op(0, 32'h8765_4321, 32'd0, 1'b1, 1'b0, n);
        check("div_y0_q", quot, 32'hFFFF_FFFF);
        check("div_y0_r", rem, 32'h8765_4321);
        drop();

        // FP add and conversions
        run_op(1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, n);
        check("fad_cyc", 32'(n), 32'd2);
        check("fad_1p2", fsum, 32'h4040_0000);
        drop();
        run_op(1, 32'h3F80_0000, 32'hBF80_0000, 1'b0, 1'b0, n);
        check("fad_cancel", fsum, 32'h0);
        drop();
        run_op(1, 32'h3FC0_0000, 32'hBE80_0000, 1'b0, 1'b0, n);
        check("fad_sub", fsum, 32'h3FA0_0000);
        drop();
        run_op(1, 32'h7F00_0000, 32'h7F00_0000, 1'b0, 1'b0, n);
        check("fad_ovf", fsum, 32'h7F80_0000);
        drop();
        run_op(1, 32'hFFFF_FFFD, 32'h1234_5678, 1'b1, 1'b0, n);
        check("flt_m3", fsum, 32'hC040_0000);
        drop();
        run_op(1, 32'h0100_0001, 32'h0, 1'b1, 1'b0, n);
        check("flt_round", fsum, 32'h4B80_0001);
        drop();
        run_op(1, 32'd5, 32'h0, 1'b1, 1'b1, n);
        check("flt_uv", fsum, 32'h40A0_0000);
        drop();
        run_op(1, 32'hC020_0000, 32'h0, 1'b0, 1'b1, n);
        check("floor_m2p5", fsum, 32'hFFFF_FFFD);
        drop();
        run_op(1, 32'h4F00_0000, 32'h0, 1'b0, 1'b1, n);
        check("floor_sat_p", fsum, 32'h7FFF_FFFF);
        drop();
        run_op(1, 32'hCF80_0000, 32'h0, 1'b0, 1'b1, n);
        check("floor_sat_n", fsum, 32'h8000_0000);
        drop();
        run_op(1, 32'hBF00_0000, 32'h0, 1'b0, 1'b1, n);
        check("floor_m0p5", fsum, 32'hFFFF_FFFF);
        drop();
        run_op(1, 32'h4020_0000, 32'h0, 1'b0, 1'b1, n);
        check("floor_2p5", fsum, 32'd2);
        drop();

        // FP divide
        run_op(2, 32'h0, 32'h4040_0000, 1'b0, 1'b0, n);
        check("fdv_zero", fquot, 32'h0);
        drop();
        run_op(2, 32'h40C0_0000, 32'h0, 1'b0, 1'b0, n);
        check("fdv_inf", fquot, 32'h7F80_0000);
        drop();
        run_op(2, 32'h3F80_0000, 32'h4040_0000, 1'b0, 1'b0, n);
        check("fdv_third", fquot, 32'h3EAA_AAAB);
        drop();
        run_op(2, 32'hC0C0_0000, 32'h4000_0000, 1'b0, 1'b0, n);
        check("fdv_neg", fquot, 32'hC040_0000);
        drop();
        run_op(2, 32'h3F80_0000, 32'h4080_0000, 1'b0, 1'b0, n);
        check("fdv_cyc", 32'(n), 32'd25);
        check("fdv_quarter", fquot, 32'h3E80_0000);
        drop();

        // Clock enable low for 5 cycles mid-divide
        x = 32'd100; y = 32'd7; div_sgn = 1'b0; div_run = 1'b1;
        n = 0;
        #1;
        while (div_stall && n < 200) begin
            n++;
            if (n == 10) en = 1'b0;
            if (n == 15) en = 1'b1;
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        check("en_cyc", 32'(n), 32'd38);
        check("en_q", quot, 32'd14);
        check("en_r", rem, 32'd2);
        drop();

        // Abort mid-divide, then restart from scratch
        x = 32'h3F80_0000; y = 32'h4080_0000; fdv_run = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        fdv_run = 1'b0;
        #1;
        check("abort_stall", {31'd0, fdv_stall}, 32'h0);
        @(posedge clk);
        #1;
        run_op(2, 32'h3F80_0000, 32'h4040_0000, 1'b0, 1'b0, n);
        check("restart_cyc", 32'(n), 32'd25);
        check("restart_res", fquot, 32'h3EAA_AAAB);
        drop();

        // Reset in the middle of all three engines
        x = 32'h4000_0000; y = 32'h3F80_0000;
        div_run = 1'b1; fad_run = 1'b1; fdv_run = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_quot", quot, 32'h0);
        check("mrst_rem", rem, 32'h0);
        check("mrst_fsum", fsum, 32'h0);
        check("mrst_fquot", fquot, 32'h0);
        rst = 1'b0;
        drop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
